// File: rtl/qk_mac_stage_if.sv
// qk_mac_stage_if: q/k beat input, credit-gated score output and credit return
interface qk_mac_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q_in;
  logic [7:0] k_in;
  logic       out_valid;
  logic [7:0] mac_result;
  logic       credit_return;
  logic       credit_err;
  modport master (
    output in_valid, q_in, k_in, credit_return,
    input  in_ready, out_valid, mac_result, credit_err
  );
  modport slave (
    input  in_valid, q_in, k_in, credit_return,
    output in_ready, out_valid, mac_result, credit_err
  );
endinterface

// File: rtl/qk_mac_stage.sv
// qk_mac_stage: credit-gated Q0.7 dot-product with round-half-up and saturation
module qk_mac_stage #(
  parameter int VEC_LEN = 4,
  parameter int CREDITS = 2,
  parameter int ACC_W   = 16 + $clog2(VEC_LEN)
) (
  input logic          clk,
  input logic          rst_n,
  qk_mac_stage_if.slave bus
);
  localparam int BW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic signed [ACC_W-1:0] MAXV = 127;
  localparam logic signed [ACC_W-1:0] MINV = -128;
  typedef enum logic {ACC, PEND} state_t;
  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [BW-1:0]      beat_q, beat_d;
  logic        [CW-1:0]      cred_q, cred_d;
  logic        [7:0]         res_q, res_d;
  logic                      err_q, err_d;
  logic signed [15:0]        prod;
  logic signed [ACC_W-1:0]   sum, rnd;
  logic                      fire, last, issue, ret;
  always_comb begin
    prod    = $signed(bus.q_in) * $signed(bus.k_in);
    sum     = acc_q + ACC_W'(prod);
    rnd     = (sum + ACC_W'(64)) >>> 7;
    fire    = bus.in_valid && state_q == ACC;
    last    = beat_q == BW'(VEC_LEN - 1);
    issue   = state_q == PEND && cred_q != '0;
    ret     = bus.credit_return;
    state_d = fire && last ? PEND : issue ? ACC : state_q;
    acc_d   = fire ? (last ? '0 : sum) : acc_q;
    beat_d  = fire ? (last ? '0 : beat_q + BW'(1)) : beat_q;
    res_d   = fire && last ? (rnd > MAXV ? 8'h7f : rnd < MINV ? 8'h80 : rnd[7:0]) : res_q;
    cred_d  = issue && !ret ? cred_q - CW'(1) :
              !issue && ret && cred_q != CMAX ? cred_q + CW'(1) : cred_q;
    err_d   = err_q || (ret && !issue && cred_q == CMAX);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      beat_q  <= '0;
      cred_q  <= CMAX;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      cred_q  <= cred_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end
  assign bus.in_ready   = state_q == ACC;
  assign bus.out_valid  = issue;
  assign bus.mac_result = res_q;
  assign bus.credit_err = err_q;
endmodule

// File: tb/tb_qk_mac_stage.sv
// tb_qk_mac_stage: random and directed stimulus against a transaction-level dot-product model
module tb_qk_mac_stage;
  localparam int VEC_LEN = 4;
  localparam int CREDITS = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   armed = 0;
  bit         m_pend = 0;
  logic [7:0] m_res = '0;
  int         m_cred = CREDITS;
  int         m_n = 0;
  int         m_sum = 0;
  bit         m_err = 0;
  qk_mac_stage_if bus();
  qk_mac_stage #(.VEC_LEN(VEC_LEN), .CREDITS(CREDITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] sat8(input int s);
    int r;
    r = (s + 64) >>> 7;
    return r > 127 ? 8'h7f : r < -128 ? 8'h80 : 8'(r);
  endfunction
  bit  issue, ret, open;
  byte qs, ks;
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_pend = 0; m_res = '0; m_cred = CREDITS; m_err = 0; m_n = 0; m_sum = 0; armed = 1;
    end else begin
      issue = m_pend && m_cred > 0;
      ret   = bus.credit_return;
      open  = !m_pend;
      if (issue) m_pend = 0;
      if (open && bus.in_valid) begin
        qs = bus.q_in; ks = bus.k_in;
        m_sum += int'(qs) * int'(ks);
        m_n++;
        if (m_n == VEC_LEN) begin
          m_res = sat8(m_sum); m_pend = 1; m_sum = 0; m_n = 0;
        end
      end
      if (issue && !ret) m_cred--;
      else if (ret && !issue) begin
        if (m_cred == CREDITS) m_err = 1;
        else m_cred++;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("in_ready", bus.in_ready, !m_pend);
      chk("out_valid", bus.out_valid, m_pend && m_cred > 0);
      chk("mac_result", bus.mac_result, m_res);
      chk("credit_err", bus.credit_err, m_err);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] q, input logic [7:0] k);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    bus.in_valid = 1'b1; bus.q_in = q; bus.k_in = k;
    step();
    bus.in_valid = 1'b0; bus.q_in = 8'($urandom); bus.k_in = 8'($urandom);
  endtask
  task automatic vec(input logic [7:0] q1, input logic [7:0] k1, input logic [7:0] qr, input logic [7:0] kr);
    beat(q1, k1);
    for (int i = 1; i < VEC_LEN; i++) beat(qr, kr);
  endtask
  task automatic expect_res(input string nm, input logic [7:0] lit);
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk(nm, bus.mac_result, lit);
    step();
    chk({nm, "_ready_after"}, bus.in_ready, 1);
    chk({nm, "_valid_after"}, bus.out_valid, 0);
  endtask
  task automatic give_credit();
    bus.credit_return = 1'b1;
    step();
    bus.credit_return = 1'b0;
  endtask
  initial begin
    int n;
    bus.in_valid = 1'b0; bus.q_in = '0; bus.k_in = '0; bus.credit_return = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mac", bus.mac_result, 8'h00);
    chk("rst_err", bus.credit_err, 0);
    vec(8'h40, 8'h40, 8'h40, 8'h40); expect_res("sat_pos", 8'h7f); give_credit();
    vec(8'h40, 8'h20, 8'h40, 8'h20); expect_res("exact_half", 8'h40); give_credit();
    vec(8'h80, 8'h7f, 8'h80, 8'h7f); expect_res("sat_neg", 8'h80); give_credit();
    vec(8'h01, 8'h40, 8'h00, 8'h00); expect_res("round_up", 8'h01); give_credit();
    vec(8'hff, 8'h40, 8'h00, 8'h00); expect_res("round_neg_half", 8'h00); give_credit();
    vec(8'h40, 8'h20, 8'h40, 8'h20);
    chk("simul_valid", bus.out_valid, 1);
    give_credit();
    chk("simul_no_err", bus.credit_err, 0);
    give_credit();
    chk("err_at_full", bus.credit_err, 1);
    repeat (5) step();
    chk("err_sticky", bus.credit_err, 1);
    vec(8'h40, 8'h20, 8'h40, 8'h20); expect_res("exh_1", 8'h40);
    vec(8'h40, 8'h40, 8'h40, 8'h40); expect_res("exh_2", 8'h7f);
    vec(8'h01, 8'h40, 8'h00, 8'h00);
    chk("stall_valid", bus.out_valid, 0);
    chk("stall_ready", bus.in_ready, 0);
    repeat (8) begin
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    chk("stall_valid_late", bus.out_valid, 0);
    chk("stall_ready_late", bus.in_ready, 0);
    chk("stall_mac", bus.mac_result, 8'h01);
    give_credit();
    expect_res("after_return", 8'h01);
    give_credit(); give_credit();
    beat(8'h40, 8'h40); beat(8'h40, 8'h40);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_err", bus.credit_err, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_valid", bus.out_valid, 0);
    vec(8'h40, 8'h20, 8'h40, 8'h20);
    chk("mid_rst_valid_once", bus.out_valid, 1);
    chk("mid_rst_mac", bus.mac_result, 8'h40);
    n = 0;
    repeat (10) begin
      step();
      n += int'(bus.out_valid);
    end
    chk("mid_rst_extra_pulses", n, 0);
    give_credit();
    chk("mid_rst_credit_restore", bus.credit_err, 0);
    give_credit();
    chk("mid_rst_credit_full", bus.credit_err, 1);
    repeat (3000) begin
      bus.in_valid = 1'($urandom);
      bus.q_in = 8'($urandom);
      bus.k_in = 8'($urandom);
      bus.credit_return = ($urandom % 4) == 0;
      rst_n = ($urandom % 400) != 0;
      step();
    end
    bus.in_valid = 1'b0; bus.credit_return = 1'b0; rst_n = 1'b1;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
